audio_sample_fifo: RTL and testbench
====================================

AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of each channel sample (signed, two's complement).
REQ-002 Parameter DEPTH, default 8, number of stereo pairs stored; SHALL be a power of two, >= 2.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 ADCLRC  input  1  reset, asynchronous, active-low.
REQ-005 in_left_data  input  DATA_WIDTH  left sample from I2S receiver, signed.
REQ-006 in_right_data  input  DATA_WIDTH  right sample from I2S receiver, signed.
REQ-007 in_valid  input  1  one-cycle pulse: the pair on in_left_data/in_right_data is new and stable this cycle.
REQ-008 out_left_data  output  DATA_WIDTH  left sample at FIFO head, signed.
REQ-009 out_right_data  output  DATA_WIDTH  right sample at FIFO head, signed.
REQ-010 out_valid  output  1  head pair valid (FIFO not empty).
REQ-011 out_ready  input  1  consumer accepts head pair when high with out_valid.
REQ-012 level  output  $clog2(DEPTH)+1  number of stored pairs, 0..DEPTH.
REQ-013 overflow  output  1  sticky: a pair was dropped because the FIFO was full.
REQ-014 clear_flags  input  1  synchronous clear of overflow and peak registers.
REQ-015 peak_left  output  DATA_WIDTH-1  largest |left| written since last clear, unsigned.
REQ-016 peak_right  output  DATA_WIDTH-1  largest |right| written since last clear, unsigned.

Function
REQ-017 Write: in_valid high and level < DEPTH -> pair stored at write pointer, write pointer +1, same edge.
REQ-018 Read: out_valid && out_ready -> head pair consumed, read pointer +1, same edge.
REQ-019 Pointers SHALL be $clog2(DEPTH)+1 bits; wrap modulo 2*DEPTH; full = MSBs differ and LSBs equal; empty = pointers equal.
REQ-020 out_left_data/out_right_data SHALL show the head entry combinationally from storage (first-word fall-through); a pair written at edge N SHALL have out_valid high after edge N, zero-cycle read latency.
REQ-021 Output data SHALL hold when out_valid low or out_ready low; values while empty are don't-care, checked only with out_valid.
REQ-022 Simultaneous write and read, not full: both occur, level unchanged.
REQ-023 Simultaneous write and read when full: read occurs, write is dropped, overflow set, level becomes DEPTH-1.
REQ-024 Write when full without read: pair dropped, storage and pointers unchanged, overflow set next edge.
REQ-025 Read when empty: ignored, no pointer change, no underflow state.
REQ-026 level SHALL equal write pointer minus read pointer (modulo 2*DEPTH) and update the same edge as the pointer change.
REQ-027 Peak: on each accepted write, peak_x <= max(peak_x, |sample|); |most-negative| saturates to 2^(DATA_WIDTH-1)-1.
REQ-028 Dropped writes SHALL NOT update peaks.
REQ-029 clear_flags high: overflow <= 0, peaks <= 0; if an overflow or accepted write occurs the same edge, set/update wins (clear applied first, then new event: overflow = 1, peak = |new sample|).
REQ-030 clear_flags SHALL NOT affect storage, pointers or level.

Reset
REQ-031 ADCLRC low SHALL immediately force: pointers 0, level 0, out_valid 0, overflow 0, peak_left 0, peak_right 0.
REQ-032 Storage array SHALL NOT require reset; out_left_data/out_right_data read 0 during and after reset until first write.
REQ-033 Reset release is asynchronous in effect only for assertion; logic resumes on first clk edge with ADCLRC high; in_valid on that edge is accepted.
REQ-034 Reset mid-operation SHALL discard all stored pairs; no partial pair is presented afterward.

Verification
REQ-035 Write pairs (0x0001,0xFFFF),(0x7FFF,0x8000) with out_ready=0 -> level 2, head (0x0001,0xFFFF), peaks 0x7FFF/0x7FFF.
REQ-036 Fill 8 pairs, write 9th (0x1234,0x5678) -> overflow 1, level 8, head order unchanged, drained data = first 8 pairs in order.
REQ-037 Full, in_valid and out_ready same cycle -> level 7, overflow 1, new pair not stored.
REQ-038 Level 3, in_valid and out_ready every cycle for 20 cycles -> level stays 3, output sequence equals input delayed by 3 pairs, pointers wrap cleanly.
REQ-039 clear_flags with overflow set and no write -> overflow 0, peaks 0, level unchanged.
REQ-040 Level 5, pull ADCLRC low mid-cycle -> level 0, out_valid 0 without a clk edge; after release, first write appears at head.

Source files
------------

// File: rtl/audio_sample_fifo.sv
// Stereo sample FIFO between an I2S receiver and a consumer: first-word fall-through,
// sticky overflow on dropped pairs, and per-channel peak-magnitude tracking.

module audio_sample_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8
) (
   input  logic                          clk,
   input  logic                          ADCLRC,
   input  logic [DATA_WIDTH-1:0]         in_left_data,
   input  logic [DATA_WIDTH-1:0]         in_right_data,
   input  logic                          in_valid,
   output logic [DATA_WIDTH-1:0]         out_left_data,
   output logic [DATA_WIDTH-1:0]         out_right_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(DEPTH):0]        level,
   output logic                          overflow,
   input  logic                          clear_flags,
   output logic [DATA_WIDTH-2:0]         peak_left,
   output logic [DATA_WIDTH-2:0]         peak_right
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int PTR_W  = ADDR_W + 1;

   // Magnitude of a signed sample; the most negative code saturates to the largest positive.
   function automatic logic [DATA_WIDTH-2:0] abs_sat(input logic [DATA_WIDTH-1:0] s);
      logic [DATA_WIDTH-1:0] n;
      if (s[DATA_WIDTH-1]) begin
         n = ~s + DATA_WIDTH'(1);
      end else begin
         n = s;
      end
      if (n[DATA_WIDTH-1]) begin
         abs_sat = {(DATA_WIDTH-1){1'b1}};
      end else begin
         abs_sat = n[DATA_WIDTH-2:0];
      end
   endfunction

   logic [DATA_WIDTH-1:0] mem_left_r  [DEPTH];
   logic [DATA_WIDTH-1:0] mem_right_r [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [PTR_W-1:0]      rd_ptr_r;
   logic                  overflow_r;
   logic [DATA_WIDTH-2:0] peak_left_r;
   logic [DATA_WIDTH-2:0] peak_right_r;

   logic                  full_s;
   logic                  empty_s;
   logic                  wr_en_s;
   logic                  rd_en_s;
   logic                  drop_s;
   logic [DATA_WIDTH-2:0] abs_left_s;
   logic [DATA_WIDTH-2:0] abs_right_s;
   logic [DATA_WIDTH-2:0] peak_left_nxt_s;
   logic [DATA_WIDTH-2:0] peak_right_nxt_s;
   logic                  overflow_nxt_s;

   assign full_s  = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                    (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]);
   assign empty_s = (wr_ptr_r == rd_ptr_r);

   // Write/read qualification; a write into a full FIFO is dropped even if a read frees a slot.
   always_comb begin
      wr_en_s = 1'b0;
      rd_en_s = 1'b0;
      drop_s  = 1'b0;
      if (in_valid && !full_s) begin
         wr_en_s = 1'b1;
      end else begin
         drop_s = in_valid;
      end
      if (out_ready && !empty_s) begin
         rd_en_s = 1'b1;
      end else begin
         rd_en_s = 1'b0;
      end
   end

   assign abs_left_s  = abs_sat(in_left_data);
   assign abs_right_s = abs_sat(in_right_data);

   // Flag next-state: clear is applied first, then any new overflow or accepted sample on top.
   always_comb begin
      peak_left_nxt_s  = peak_left_r;
      peak_right_nxt_s = peak_right_r;
      overflow_nxt_s   = overflow_r;
      if (clear_flags) begin
         peak_left_nxt_s  = {(DATA_WIDTH-1){1'b0}};
         peak_right_nxt_s = {(DATA_WIDTH-1){1'b0}};
         overflow_nxt_s   = 1'b0;
      end else begin
         overflow_nxt_s   = overflow_r;
      end
      if (drop_s) begin
         overflow_nxt_s = 1'b1;
      end else begin
         overflow_nxt_s = overflow_nxt_s;
      end
      if (wr_en_s && (abs_left_s > peak_left_nxt_s)) begin
         peak_left_nxt_s = abs_left_s;
      end else begin
         peak_left_nxt_s = peak_left_nxt_s;
      end
      if (wr_en_s && (abs_right_s > peak_right_nxt_s)) begin
         peak_right_nxt_s = abs_right_s;
      end else begin
         peak_right_nxt_s = peak_right_nxt_s;
      end
   end

   // Sample storage; contents are never reset because the empty flag masks the head.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_left_r[wr_ptr_r[ADDR_W-1:0]]  <= in_left_data;
         mem_right_r[wr_ptr_r[ADDR_W-1:0]] <= in_right_data;
      end
   end

   // Pointers and sticky status registers.
   always_ff @(posedge clk or negedge ADCLRC) begin
      if (!ADCLRC) begin
         wr_ptr_r     <= {PTR_W{1'b0}};
         rd_ptr_r     <= {PTR_W{1'b0}};
         overflow_r   <= 1'b0;
         peak_left_r  <= {(DATA_WIDTH-1){1'b0}};
         peak_right_r <= {(DATA_WIDTH-1){1'b0}};
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         overflow_r   <= overflow_nxt_s;
         peak_left_r  <= peak_left_nxt_s;
         peak_right_r <= peak_right_nxt_s;
      end
   end

   // Fall-through head; forced to zero while empty so stale storage never leaks out.
   always_comb begin
      if (empty_s) begin
         out_left_data  = {DATA_WIDTH{1'b0}};
         out_right_data = {DATA_WIDTH{1'b0}};
      end else begin
         out_left_data  = mem_left_r[rd_ptr_r[ADDR_W-1:0]];
         out_right_data = mem_right_r[rd_ptr_r[ADDR_W-1:0]];
      end
   end

   assign out_valid  = !empty_s;
   assign level      = wr_ptr_r - rd_ptr_r;
   assign overflow   = overflow_r;
   assign peak_left  = peak_left_r;
   assign peak_right = peak_right_r;

   audio_sample_fifo_chk #(
      .DEPTH (DEPTH)
   ) u_chk (
      .clk       (clk),
      .ADCLRC    (ADCLRC),
      .level     (level),
      .out_valid (out_valid)
   );

endmodule

// Structural invariants of the FIFO occupancy.
module audio_sample_fifo_chk #(
   parameter int DEPTH = 8
) (
   input logic                   clk,
   input logic                   ADCLRC,
   input logic [$clog2(DEPTH):0] level,
   input logic                   out_valid
);

   localparam int LEVEL_W = $clog2(DEPTH) + 1;

   a_level_bound : assert property (@(posedge clk) disable iff (!ADCLRC)
      level <= LEVEL_W'(DEPTH));

   a_valid_level : assert property (@(posedge clk) disable iff (!ADCLRC)
      out_valid == (level != LEVEL_W'(0)));

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo with hand-computed expectations.

module tb_audio_sample_fifo;

   logic        clk;
   logic        ADCLRC;
   logic [15:0] in_left_data;
   logic [15:0] in_right_data;
   logic        in_valid;
   logic [15:0] out_left_data;
   logic [15:0] out_right_data;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  level;
   logic        overflow;
   logic        clear_flags;
   logic [14:0] peak_left;
   logic [14:0] peak_right;

   int vectors;
   int miscompares;

   audio_sample_fifo #(.DATA_WIDTH(16), .DEPTH(8)) dut (
      .clk            (clk),
      .ADCLRC         (ADCLRC),
      .in_left_data   (in_left_data),
      .in_right_data  (in_right_data),
      .in_valid       (in_valid),
      .out_left_data  (out_left_data),
      .out_right_data (out_right_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .level          (level),
      .overflow       (overflow),
      .clear_flags    (clear_flags),
      .peak_left      (peak_left),
      .peak_right     (peak_right)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      clear_flags = 1'b0;
   endtask

   task automatic put(input logic [15:0] l, input logic [15:0] r);
      in_left_data  = l;
      in_right_data = r;
      in_valid      = 1'b1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      ADCLRC        = 1'b0;
      in_left_data  = 16'h0000;
      in_right_data = 16'h0000;
      idle();

      // Reset state
      #12;
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_peakl", 32'(peak_left), 32'd0);
      chk("rst_peakr", 32'(peak_right), 32'd0);
      chk("rst_outl", 32'(out_left_data), 32'd0);

      // First edge after release accepts the write
      ADCLRC = 1'b1;
      put(16'h0001, 16'hFFFF);
      tick();
      idle();
      chk("w1_level", 32'(level), 32'd1);
      chk("w1_valid", 32'(out_valid), 32'd1);
      chk("w1_outl", 32'(out_left_data), 32'h0001);
      chk("w1_outr", 32'(out_right_data), 32'hFFFF);
      chk("w1_peakl", 32'(peak_left), 32'h0001);
      chk("w1_peakr", 32'(peak_right), 32'h0001);

      put(16'h7FFF, 16'h8000);
      tick();
      idle();
      chk("w2_level", 32'(level), 32'd2);
      chk("w2_outl", 32'(out_left_data), 32'h0001);
      chk("w2_outr", 32'(out_right_data), 32'hFFFF);
      chk("w2_peakl", 32'(peak_left), 32'h7FFF);
      chk("w2_peakr", 32'(peak_right), 32'h7FFF);

      // Clear flags without a write leaves storage alone
      clear_flags = 1'b1;
      tick();
      idle();
      chk("clr_peakl", 32'(peak_left), 32'd0);
      chk("clr_peakr", 32'(peak_right), 32'd0);
      chk("clr_level", 32'(level), 32'd2);

      // Drain, then read while empty
      out_ready = 1'b1;
      tick();
      chk("rd1_outl", 32'(out_left_data), 32'h7FFF);
      chk("rd1_outr", 32'(out_right_data), 32'h8000);
      chk("rd1_level", 32'(level), 32'd1);
      tick();
      chk("rd2_level", 32'(level), 32'd0);
      chk("rd2_valid", 32'(out_valid), 32'd0);
      tick();
      idle();
      chk("rde_level", 32'(level), 32'd0);

      // Fill to DEPTH, then one dropped write
      for (int i = 0; i < 8; i++) begin
         put(16'h1000 + 16'(i), 16'h2000 + 16'(i));
         tick();
      end
      idle();
      chk("full_level", 32'(level), 32'd8);
      chk("full_ovf0", 32'(overflow), 32'd0);
      put(16'h1234, 16'h5678);
      tick();
      idle();
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_level", 32'(level), 32'd8);
      chk("ovf_outl", 32'(out_left_data), 32'h1000);
      chk("ovf_outr", 32'(out_right_data), 32'h2000);
      chk("ovf_peakl", 32'(peak_left), 32'h1007);
      chk("ovf_peakr", 32'(peak_right), 32'h2007);

      // Clear with overflow set
      clear_flags = 1'b1;
      tick();
      idle();
      chk("clr2_ovf", 32'(overflow), 32'd0);
      chk("clr2_peakl", 32'(peak_left), 32'd0);
      chk("clr2_level", 32'(level), 32'd8);

      // Full with simultaneous write and read
      put(16'hAAAA, 16'h5555);
      out_ready = 1'b1;
      tick();
      idle();
      chk("fwr_level", 32'(level), 32'd7);
      chk("fwr_ovf", 32'(overflow), 32'd1);
      chk("fwr_peakl", 32'(peak_left), 32'd0);

      for (int i = 1; i < 8; i++) begin
         chk("drain_l", 32'(out_left_data), 32'h1000 + 32'(i));
         chk("drain_r", 32'(out_right_data), 32'h2000 + 32'(i));
         out_ready = 1'b1;
         tick();
      end
      idle();
      chk("drain_level", 32'(level), 32'd0);
      chk("drain_valid", 32'(out_valid), 32'd0);

      // Clear and write on the same edge: new sample wins over old peak
      put(16'h7000, 16'h7000);
      tick();
      chk("pk_pre", 32'(peak_left), 32'h7000);
      put(16'hFFFE, 16'h0003);
      clear_flags = 1'b1;
      tick();
      idle();
      chk("cw_ovf", 32'(overflow), 32'd0);
      chk("cw_peakl", 32'(peak_left), 32'h0002);
      chk("cw_peakr", 32'(peak_right), 32'h0003);
      chk("cw_level", 32'(level), 32'd2);
      out_ready = 1'b1;
      tick();
      tick();
      idle();
      chk("cw_drain", 32'(level), 32'd0);

      // Steady streaming at level 3 across pointer wrap
      for (int i = 0; i < 3; i++) begin
         put(16'h3000 + 16'(i), 16'h4000 + 16'(i));
         tick();
      end
      idle();
      chk("st_level0", 32'(level), 32'd3);
      for (int k = 0; k < 20; k++) begin
         chk("st_outl", 32'(out_left_data), 32'h3000 + 32'(k));
         chk("st_outr", 32'(out_right_data), 32'h4000 + 32'(k));
         put(16'h3003 + 16'(k), 16'h4003 + 16'(k));
         out_ready = 1'b1;
         tick();
         chk("st_level", 32'(level), 32'd3);
      end
      idle();
      chk("st_head", 32'(out_left_data), 32'h3014);

      // Asynchronous reset mid-cycle at level 5
      put(16'h0111, 16'h0222);
      tick();
      put(16'h0333, 16'h0444);
      tick();
      idle();
      chk("ar_level5", 32'(level), 32'd5);
      #2;
      ADCLRC = 1'b0;
      #1;
      chk("ar_level", 32'(level), 32'd0);
      chk("ar_valid", 32'(out_valid), 32'd0);
      chk("ar_outl", 32'(out_left_data), 32'd0);
      chk("ar_peakl", 32'(peak_left), 32'd0);
      tick();
      #2;
      ADCLRC = 1'b1;
      put(16'h0BAD, 16'h0F00);
      tick();
      idle();
      chk("ar_w_level", 32'(level), 32'd1);
      chk("ar_w_outl", 32'(out_left_data), 32'h0BAD);
      chk("ar_w_outr", 32'(out_right_data), 32'h0F00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
